// File: rtl/instr_seq_if.sv
// Handshake bundle between the instruction sequencer and the 141L datapath:
// IR fields and memory status in, control strobes and status out.
interface instr_seq_if #(
    parameter int CNT_WIDTH = 16
);
    // IR fields and datapath status
    logic                 start;
    logic                 format;
    logic [3:0]           opcode;
    logic                 sign;
    logic                 branch_cond;
    logic                 mem_ready;

    // Control strobes and status
    logic                 ir_load;
    logic                 pc_inc;
    logic                 pc_load;
    logic                 pc_src;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic [1:0]           write_src;
    logic                 cpin;
    logic                 cpout;
    logic                 halted;
    logic                 mem_error;
    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] retired;

    modport master (
        input  start, format, opcode, sign, branch_cond, mem_ready,
        output ir_load, pc_inc, pc_load, pc_src, mem_read, mem_write,
               reg_write, write_src, cpin, cpout, halted, mem_error,
               state, retired
    );

    modport slave (
        output start, format, opcode, sign, branch_cond, mem_ready,
        input  ir_load, pc_inc, pc_load, pc_src, mem_read, mem_write,
               reg_write, write_src, cpin, cpout, halted, mem_error,
               state, retired
    );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 141L datapath with
// memory wait/timeout handling, sticky halt and a retired-instruction counter.
module instr_sequencer #(
    parameter int CNT_WIDTH   = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    instr_seq_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_IMM, C_ALU, C_LOAD, C_STORE, C_BRANCH,
        C_JUMP, C_CPIN, C_CPOUT, C_HALT, C_NOP
    } cls_t;

    localparam logic [1:0] WS_MEM = 2'b00;
    localparam logic [1:0] WS_IMM = 2'b01;
    localparam logic [1:0] WS_RES = 2'b10;
    localparam logic [1:0] WS_ALU = 2'b11;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    function automatic cls_t classify(input logic fmt, input logic [3:0] op, input logic sg);
        cls_t c;
        c = C_NOP;
        if (!fmt) begin
            c = C_IMM;
        end else begin
            case (op)
                4'b0000, 4'b0101, 4'b1010: c = C_ALU;
                4'b0001:                   c = C_LOAD;
                4'b0010:                   c = C_STORE;
                4'b0011:                   c = C_JUMP;
                4'b0100:                   c = C_BRANCH;
                4'b0111:                   c = sg ? C_CPOUT : C_CPIN;
                4'b1011:                   c = C_HALT;
                default:                   c = C_NOP;
            endcase
        end
        return c;
    endfunction

    state_t               state_reg, state_next;
    logic                 format_reg;
    logic [3:0]           opcode_reg;
    logic                 sign_reg;
    logic [7:0]           wait_reg, wait_next;
    logic [CNT_WIDTH-1:0] retired_reg;
    logic                 halted_reg;
    logic                 mem_error_reg;

    cls_t cls_dec;   // class of the instruction currently presented on the IR fields
    cls_t cls_cur;   // class of the instruction latched in DECODE

    logic       ir_load, pc_inc, pc_load, pc_src;
    logic       mem_read, mem_write, reg_write, cpin, cpout;
    logic [1:0] write_src;
    logic       retire;

    assign cls_dec = classify(bus.format, bus.opcode, bus.sign);
    assign cls_cur = classify(format_reg, opcode_reg, sign_reg);

    always_comb begin
        state_next = state_reg;
        wait_next  = 8'd0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        pc_src     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        write_src  = WS_IMM;
        cpin       = 1'b0;
        cpout      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (bus.start) begin
                    state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                ir_load    = 1'b1;
                state_next = S_DECODE;
            end

            S_DECODE: begin
                case (cls_dec)
                    C_IMM:           state_next = S_WB;
                    C_LOAD, C_STORE: state_next = S_MEM;
                    C_HALT:          state_next = S_HALT;
                    default:         state_next = S_EXEC;
                endcase
            end

            S_EXEC: begin
                case (cls_cur)
                    C_ALU: begin
                        state_next = S_WB;
                    end
                    C_BRANCH: begin
                        // Taken/not-taken follows the live flag, not a latched copy.
                        pc_load    = bus.branch_cond;
                        pc_inc     = !bus.branch_cond;
                        state_next = S_FETCH;
                    end
                    C_JUMP: begin
                        pc_load    = 1'b1;
                        pc_src     = 1'b1;
                        state_next = S_FETCH;
                    end
                    C_CPOUT: begin
                        cpout      = 1'b1;
                        pc_inc     = 1'b1;
                        state_next = S_FETCH;
                    end
                    C_CPIN: begin
                        cpin       = 1'b1;
                        state_next = S_WB;
                    end
                    default: begin
                        pc_inc     = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                mem_read  = (cls_cur == C_LOAD);
                mem_write = (cls_cur != C_LOAD);
                if (bus.mem_ready) begin
                    if (cls_cur == C_LOAD) begin
                        state_next = S_WB;
                    end else begin
                        pc_inc     = 1'b1;
                        state_next = S_FETCH;
                    end
                end else if (wait_reg == WAIT_LAST) begin
                    state_next = S_ERROR;
                end else begin
                    wait_next = wait_reg + 8'd1;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                pc_inc     = 1'b1;
                state_next = S_FETCH;
                case (cls_cur)
                    C_LOAD:  write_src = WS_MEM;
                    C_ALU:   write_src = WS_ALU;
                    C_CPIN:  write_src = WS_RES;
                    default: write_src = WS_IMM;
                endcase
            end

            S_HALT:  state_next = S_HALT;
            S_ERROR: state_next = S_ERROR;
            default: state_next = S_IDLE;
        endcase
    end

    // A halt retires on entry since it never produces a PC update.
    assign retire = pc_inc | pc_load | ((state_next == S_HALT) && (state_reg != S_HALT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            format_reg    <= 1'b0;
            opcode_reg    <= 4'd0;
            sign_reg      <= 1'b0;
            wait_reg      <= 8'd0;
            retired_reg   <= '0;
            halted_reg    <= 1'b0;
            mem_error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (state_reg == S_DECODE) begin
                format_reg <= bus.format;
                opcode_reg <= bus.opcode;
                sign_reg   <= bus.sign;
            end
            if (retire) begin
                retired_reg <= retired_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (state_next == S_HALT) begin
                halted_reg <= 1'b1;
            end
            if (state_next == S_ERROR) begin
                mem_error_reg <= 1'b1;
            end
        end
    end

    assign bus.ir_load   = ir_load;
    assign bus.pc_inc    = pc_inc;
    assign bus.pc_load   = pc_load;
    assign bus.pc_src    = pc_src;
    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.reg_write = reg_write;
    assign bus.write_src = write_src;
    assign bus.cpin      = cpin;
    assign bus.cpout     = cpout;
    assign bus.halted    = halted_reg;
    assign bus.mem_error = mem_error_reg;
    assign bus.state     = state_reg;
    assign bus.retired   = retired_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: per-instruction expected cycle traces built from
// the instruction-class rules, compared against the DUT on every cycle.
module tb_instr_sequencer;

    localparam int MEM_TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_seq_if #(.CNT_WIDTH(16)) bus();

    instr_sequencer #(.CNT_WIDTH(16), .MEM_TIMEOUT(MEM_TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [2:0]  state;
        logic        ir_load;
        logic        pc_inc;
        logic        pc_load;
        logic        pc_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic [1:0]  write_src;
        logic        cpin;
        logic        cpout;
        logic        halted;
        logic        mem_error;
        logic [15:0] retired;
    } obs_t;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int dut_mr = 0;

    // Architectural model state: retired count and sticky flags.
    logic [15:0] ret_m  = 16'd0;
    logic        halt_m = 1'b0;
    logic        err_m  = 1'b0;

    logic       fmt_v = 1'b0;
    logic [3:0] op_v  = 4'd0;
    logic       sg_v  = 1'b0;
    logic       bc_v  = 1'b0;

    function automatic obs_t sample();
        obs_t o;
        o.state     = bus.state;
        o.ir_load   = bus.ir_load;
        o.pc_inc    = bus.pc_inc;
        o.pc_load   = bus.pc_load;
        o.pc_src    = bus.pc_src;
        o.mem_read  = bus.mem_read;
        o.mem_write = bus.mem_write;
        o.reg_write = bus.reg_write;
        o.write_src = bus.write_src;
        o.cpin      = bus.cpin;
        o.cpout     = bus.cpout;
        o.halted    = bus.halted;
        o.mem_error = bus.mem_error;
        o.retired   = bus.retired;
        return o;
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t o;
        o           = '0;
        o.state     = st;
        o.write_src = 2'b01;
        o.halted    = halt_m;
        o.mem_error = err_m;
        o.retired   = ret_m;
        return o;
    endfunction

    // Instruction classes: 0 imm, 1 alu, 2 load, 3 store, 4 branch, 5 jump,
    // 6 cpin, 7 cpout, 8 halt, 9 nop.
    function automatic int cls_of(input logic fmt, input logic [3:0] op, input logic sg);
        if (!fmt) return 0;
        if (op == 4'd0 || op == 4'd5 || op == 4'd10) return 1;
        if (op == 4'd1) return 2;
        if (op == 4'd2) return 3;
        if (op == 4'd4) return 4;
        if (op == 4'd3) return 5;
        if (op == 4'd7) return sg ? 7 : 6;
        if (op == 4'd11) return 8;
        return 9;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs on the falling edge, compare 2 ns later.
    task automatic cyc(input obs_t e, input bit chk, input logic st, input logic rs, input logic rdy);
        obs_t a;
        @(negedge clk);
        bus.start       = st;
        reset           = rs;
        bus.mem_ready   = rdy;
        bus.format      = fmt_v;
        bus.opcode      = op_v;
        bus.sign        = sg_v;
        bus.branch_cond = bc_v;
        #2;
        a = sample();
        ncyc++;
        if (a.mem_read) dut_mr++;
        if (chk) begin
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_%0d act=%h exp=%h (state act %0d exp %0d)",
                         ncyc, a, e, a.state, e.state);
            end
        end
    endtask

    task automatic lit(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, expv);
        end
    endtask

    // n = MEM cycle on which mem_ready rises (0 = never).
    task automatic run_instr(input logic fmt, input logic [3:0] op, input logic sg,
                             input logic bc, input int n, output int cycles);
        obs_t e;
        int   cls;
        int   c0;
        bit   done;
        logic rdy;
        c0    = ncyc;
        fmt_v = fmt;
        op_v  = op;
        sg_v  = sg;
        bc_v  = bc;
        cls   = cls_of(fmt, op, sg);

        e = base(3'd1); e.ir_load = 1'b1;
        cyc(e, 1, rbit(), 1'b0, rbit());
        e = base(3'd2);
        cyc(e, 1, rbit(), 1'b0, rbit());

        case (cls)
            0, 1, 6: begin
                if (cls != 0) begin
                    e = base(3'd3);
                    e.cpin = (cls == 6);
                    cyc(e, 1, rbit(), 1'b0, rbit());
                end
                e = base(3'd5);
                e.reg_write = 1'b1;
                e.pc_inc    = 1'b1;
                e.write_src = (cls == 0) ? 2'b01 : (cls == 1) ? 2'b11 : 2'b10;
                cyc(e, 1, rbit(), 1'b0, rbit());
                ret_m++;
            end
            4, 5, 7, 9: begin
                e = base(3'd3);
                if (cls == 4) begin
                    e.pc_load = bc;
                    e.pc_inc  = !bc;
                end else if (cls == 5) begin
                    e.pc_load = 1'b1;
                    e.pc_src  = 1'b1;
                end else begin
                    e.pc_inc = 1'b1;
                    e.cpout  = (cls == 7);
                end
                cyc(e, 1, rbit(), 1'b0, rbit());
                ret_m++;
            end
            2, 3: begin
                done = 1'b0;
                for (int k = 1; k <= MEM_TO && !done; k++) begin
                    rdy = (k == n);
                    e = base(3'd4);
                    e.mem_read  = (cls == 2);
                    e.mem_write = (cls == 3);
                    e.pc_inc    = (cls == 3) && rdy;
                    cyc(e, 1, rbit(), 1'b0, rdy);
                    done = rdy;
                end
                if (!done) begin
                    err_m = 1'b1;
                    e = base(3'd7);
                    cyc(e, 1, rbit(), 1'b0, rbit());
                end else if (cls == 2) begin
                    e = base(3'd5);
                    e.reg_write = 1'b1;
                    e.pc_inc    = 1'b1;
                    e.write_src = 2'b00;
                    cyc(e, 1, rbit(), 1'b0, rbit());
                    ret_m++;
                end else begin
                    ret_m++;
                end
            end
            default: begin
                halt_m = 1'b1;
                ret_m++;
                e = base(3'd6);
                cyc(e, 1, rbit(), 1'b0, rbit());
            end
        endcase
        cycles = ncyc - c0;
    endtask

    task automatic do_reset_and_start();
        obs_t e;
        e = '0;
        cyc(e, 0, 1'b0, 1'b1, 1'b0);
        ret_m  = 16'd0;
        halt_m = 1'b0;
        err_m  = 1'b0;
        cyc(base(3'd0), 1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        obs_t e;
        int   c;
        int   mr0;
        logic [3:0] op;
        logic [15:0] ret_before;

        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.format      = 1'b0;
        bus.opcode      = 4'd0;
        bus.sign        = 1'b0;
        bus.branch_cond = 1'b0;
        bus.mem_ready   = 1'b0;

        e = '0;
        cyc(e, 0, 1'b0, 1'b1, 1'b0);
        cyc(e, 0, 1'b0, 1'b1, 1'b0);
        cyc(base(3'd0), 1, 1'b1, 1'b0, 1'b0);

        // Directed instructions
        run_instr(1'b1, 4'd0, 1'b0, 1'b0, 0, c);
        lit("add_cycles", c, 4);
        @(posedge clk); #1;
        lit("add_retired", int'(bus.retired), 1);

        mr0 = dut_mr;
        run_instr(1'b1, 4'd1, 1'b0, 1'b0, 3, c);
        lit("load_cycles", c, 6);
        lit("load_mem_read_cycles", dut_mr - mr0, 3);
        @(posedge clk); #1;
        lit("load_retired", int'(bus.retired), 2);

        run_instr(1'b1, 4'd4, 1'b0, 1'b0, 0, c);  lit("branch_nt_cycles", c, 3);
        run_instr(1'b1, 4'd4, 1'b0, 1'b1, 0, c);  lit("branch_t_cycles", c, 3);
        run_instr(1'b0, 4'd11, 1'b0, 1'b0, 0, c); lit("imm_cycles", c, 3);
        run_instr(1'b1, 4'd3, 1'b0, 1'b0, 0, c);  lit("jump_cycles", c, 3);
        run_instr(1'b1, 4'd7, 1'b1, 1'b0, 0, c);  lit("cpout_cycles", c, 3);
        run_instr(1'b1, 4'd7, 1'b0, 1'b0, 0, c);  lit("cpin_cycles", c, 4);
        run_instr(1'b1, 4'd2, 1'b0, 1'b0, 1, c);  lit("store1_cycles", c, 3);
        run_instr(1'b1, 4'd2, 1'b0, 1'b0, MEM_TO, c); lit("store_last_cycles", c, 2 + MEM_TO);
        run_instr(1'b1, 4'd6, 1'b0, 1'b0, 0, c);  lit("nop_cycles", c, 3);
        lit("model_retired", int'(ret_m), 11);

        // Randomized instruction stream (halt excluded; it is terminal)
        for (int i = 0; i < 250; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'd11) op = 4'd0;
            run_instr(($urandom_range(0, 3) != 0), op, rbit(), rbit(),
                      $urandom_range(1, MEM_TO), c);
        end

        // Reset during the 2nd MEM cycle of a load
        fmt_v = 1'b1; op_v = 4'd1; sg_v = 1'b0;
        e = base(3'd1); e.ir_load = 1'b1;
        cyc(e, 1, 1'b0, 1'b0, 1'b0);
        cyc(base(3'd2), 1, 1'b0, 1'b0, 1'b0);
        e = base(3'd4); e.mem_read = 1'b1;
        cyc(e, 1, 1'b0, 1'b0, 1'b0);
        cyc(e, 1, 1'b0, 1'b1, 1'b0);
        ret_m = 16'd0;
        cyc(base(3'd0), 1, 1'b0, 1'b0, 1'b1);
        cyc(base(3'd0), 1, 1'b1, 1'b0, 1'b0);

        // Store that never sees mem_ready
        ret_before = ret_m;
        run_instr(1'b1, 4'd2, 1'b0, 1'b0, 0, c);
        lit("timeout_cycles", c, 3 + MEM_TO);
        for (int i = 0; i < 3; i++) cyc(base(3'd7), 1, rbit(), 1'b0, rbit());
        lit("timeout_retired", int'(bus.retired), int'(ret_before));

        // Halt is sticky and ignores start
        do_reset_and_start();
        run_instr(1'b1, 4'd11, 1'b0, 1'b0, 0, c);
        lit("halt_cycles", c, 3);
        for (int i = 0; i < 10; i++) cyc(base(3'd6), 1, 1'(i % 2 == 0), 1'b0, rbit());
        lit("halt_retired", int'(bus.retired), 1);
        e = '0;
        cyc(e, 0, 1'b0, 1'b1, 1'b0);
        halt_m = 1'b0;
        ret_m  = 16'd0;
        cyc(base(3'd0), 1, 1'b0, 1'b0, 1'b0);
        lit("post_reset_halted", int'(bus.halted), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
